// File: rtl/memory_stage.sv
// Memory stage of the five-stage RISC-V pipeline: E/M register, data-memory
// request/ready handshake with timeout, lane steering and load extension.
module memory_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       Funct3E,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic [4:0]       RdE,
    output logic             DMemReq,
    output logic             DMemWe,
    output logic [WIDTH-1:0] DMemAddr,
    output logic [3:0]       DMemBe,
    output logic [WIDTH-1:0] DMemWData,
    input  logic [WIDTH-1:0] DMemRData,
    input  logic             DMemReady,
    output logic             StallM,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             MemFaultM,
    output logic             DbgState
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic [1:0]       result_src_q, result_src_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic [4:0]       rd_q, rd_d;

    logic             store_m, load_m, mem_op, funct_ok, misaligned, bad_op, legal_op;
    logic             timeout_hit, complete;
    logic [WIDTH-1:0] lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
            alu_q        <= '0;
            wdata_q      <= '0;
            pc4_q        <= '0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            alu_q        <= alu_d;
            wdata_q      <= wdata_d;
            pc4_q        <= pc4_d;
            rd_q         <= rd_d;
        end
    end

    // E/M register holds while the access is outstanding.
    always_comb begin
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        alu_d        = alu_q;
        wdata_d      = wdata_q;
        pc4_d        = pc4_q;
        rd_d         = rd_q;
        if (!StallM) begin
            reg_write_d  = RegWriteE;
            mem_write_d  = MemWriteE;
            result_src_d = ResultSrcE;
            funct3_d     = Funct3E;
            alu_d        = ALUResultE;
            wdata_d      = WriteDataE;
            pc4_d        = PCPlus4E;
            rd_d         = RdE;
        end
    end

    // Store wins if both load and store are flagged.
    always_comb begin
        store_m  = mem_write_q;
        load_m   = (result_src_q == 2'b01) && !mem_write_q;
        mem_op   = store_m || load_m;
        funct_ok = 1'b0;
        case (funct3_q)
            3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
            3'b100, 3'b101:         funct_ok = load_m;
            default:                funct_ok = 1'b0;
        endcase
        misaligned = ((funct3_q[1:0] == 2'b01) && alu_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (alu_q[1:0] != 2'b00));
        bad_op      = mem_op && (!funct_ok || misaligned);
        legal_op    = mem_op && !bad_op;
        timeout_hit = (state_q == S_WAIT) && (cnt_q == TMO) && !DMemReady;
        DMemReq     = legal_op && !timeout_hit;
        complete    = DMemReq && DMemReady;
        StallM      = legal_op && !complete && !timeout_hit;
        MemFaultM   = bad_op || timeout_hit;
        RegWriteM   = reg_write_q && !StallM && !MemFaultM;
        DMemWe      = DMemReq && store_m;
        DbgState    = (state_q == S_WAIT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (legal_op && !DMemReady) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            S_WAIT: begin
                if (DMemReady || (cnt_q == TMO)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lane steering for stores and extraction/extension for loads.
    always_comb begin
        DMemAddr = {alu_q[WIDTH-1:2], 2'b00};
        case (funct3_q[1:0])
            2'b00: begin
                DMemBe    = 4'b0001 << alu_q[1:0];
                DMemWData = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                DMemBe    = 4'b0011 << alu_q[1:0];
                DMemWData = {2{wdata_q[15:0]}};
            end
            default: begin
                DMemBe    = 4'b1111;
                DMemWData = wdata_q;
            end
        endcase
        lane = DMemRData >> {alu_q[1:0], 3'b000};
        ReadDataM = '0;
        if (load_m && complete) begin
            case (funct3_q)
                3'b000:  ReadDataM = {{24{lane[7]}}, lane[7:0]};
                3'b001:  ReadDataM = {{16{lane[15]}}, lane[15:0]};
                3'b100:  ReadDataM = {24'd0, lane[7:0]};
                3'b101:  ReadDataM = {16'd0, lane[15:0]};
                default: ReadDataM = lane;
            endcase
        end
    end

    assign ResultSrcM = result_src_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_q;
    assign PCPlus4M   = pc4_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single-cycle vectors plus
// hand-written wait-state, timeout and reset-mid-access sequences.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        DMemReq, DMemWe, DMemReady;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBe;
  logic        StallM, RegWriteM, MemFaultM, DbgState;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  memory_stage #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E), .RdE(RdE),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBe(DMemBe),
    .DMemWData(DMemWData), .DMemRData(DMemRData), .DMemReady(DMemReady),
    .StallM(StallM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
    .MemFaultM(MemFaultM), .DbgState(DbgState)
  );

  typedef struct {
    logic        rw, mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu, wd, rdata;
    logic [4:0]  rd;
    logic        ready;
    logic        e_req, e_we, e_stall, e_rw, e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_e(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd);
    RegWriteE  = rw;
    MemWriteE  = mw;
    ResultSrcE = rs;
    Funct3E    = f3;
    ALUResultE = alu;
    WriteDataE = wd;
    PCPlus4E   = alu + 32'd4;
    RdE        = rd;
  endtask

  function automatic vec_t mkv(input logic rw, input logic mw, input logic [1:0] rs,
                               input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] rdata, input logic ready,
                               input logic e_req, input logic e_we, input logic [3:0] e_be,
                               input logic [31:0] e_wd, input logic e_stall,
                               input logic e_rw, input logic e_fault,
                               input logic [31:0] e_rdata);
    vec_t v;
    v.rw = rw; v.mw = mw; v.rs = rs; v.f3 = f3; v.alu = alu; v.wd = wd; v.rd = rd;
    v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_rw = e_rw; v.e_fault = e_fault; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    int   stalls;
    logic done;

    // rw mw rs f3 alu wd rd rdata ready | req we be wd stall rw fault rdata
    vecs[0]  = mkv(1,0,2'b01,3'b010,32'h100,32'h0,5'd1,32'hDEADBEEF,1, 1,0,4'hF,32'h0,0,1,0,32'hDEADBEEF);
    vecs[1]  = mkv(1,0,2'b01,3'b000,32'h103,32'h0,5'd2,32'h80123456,1, 1,0,4'h8,32'h0,0,1,0,32'hFFFFFF80);
    vecs[2]  = mkv(1,0,2'b01,3'b100,32'h103,32'h0,5'd3,32'h80123456,1, 1,0,4'h8,32'h0,0,1,0,32'h00000080);
    vecs[3]  = mkv(1,0,2'b01,3'b001,32'h102,32'h0,5'd4,32'h80123456,1, 1,0,4'hC,32'h0,0,1,0,32'hFFFF8012);
    vecs[4]  = mkv(1,0,2'b01,3'b101,32'h100,32'h0,5'd5,32'h80129876,1, 1,0,4'h3,32'h0,0,1,0,32'h00009876);
    vecs[5]  = mkv(0,1,2'b00,3'b000,32'h101,32'hA5,5'd0,32'h0,1,       1,1,4'h2,32'hA5A5A5A5,0,0,0,32'h0);
    vecs[6]  = mkv(0,1,2'b00,3'b010,32'h104,32'h12345678,5'd0,32'h0,1, 1,1,4'hF,32'h12345678,0,0,0,32'h0);
    vecs[7]  = mkv(1,0,2'b01,3'b010,32'h101,32'h0,5'd6,32'h11111111,1, 0,0,4'h0,32'h0,0,0,1,32'h0);
    vecs[8]  = mkv(1,0,2'b01,3'b011,32'h100,32'h0,5'd7,32'h22222222,1, 0,0,4'h0,32'h0,0,0,1,32'h0);
    vecs[9]  = mkv(0,1,2'b00,3'b100,32'h100,32'hFF,5'd0,32'h0,1,       0,0,4'h0,32'h0,0,0,1,32'h0);
    vecs[10] = mkv(1,0,2'b00,3'b000,32'h55,32'h0,5'd8,32'h33333333,1,  0,0,4'h0,32'h0,0,1,0,32'h0);
    vecs[11] = mkv(1,0,2'b01,3'b001,32'h101,32'h0,5'd9,32'h0,1,        0,0,4'h0,32'h0,0,0,1,32'h0);
    vecs[12] = mkv(1,0,2'b10,3'b000,32'h200,32'h0,5'd10,32'h0,0,       0,0,4'h0,32'h0,0,1,0,32'h0);

    // Reset state
    rst_n = 1'b0;
    drive_e(0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    DMemReady = 1'b0;
    DMemRData = 32'h0;
    #12;
    chk("rst req",   {31'd0, DMemReq},   32'd0);
    chk("rst stall", {31'd0, StallM},    32'd0);
    chk("rst rw",    {31'd0, RegWriteM}, 32'd0);
    chk("rst fault", {31'd0, MemFaultM}, 32'd0);
    chk("rst rdata", ReadDataM, 32'd0);
    chk("rst rd",    {27'd0, RdM}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors; consecutive loads also exercise back-to-back requests
    for (int i = 0; i < 13; i++) begin
      string n;
      n = $sformatf("v%0d", i);
      @(negedge clk);
      drive_e(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].f3, vecs[i].alu, vecs[i].wd, vecs[i].rd);
      DMemRData = vecs[i].rdata;
      DMemReady = vecs[i].ready;
      @(posedge clk);
      #1;
      chk({n, " req"},   {31'd0, DMemReq},   {31'd0, vecs[i].e_req});
      chk({n, " we"},    {31'd0, DMemWe},    {31'd0, vecs[i].e_we});
      chk({n, " stall"}, {31'd0, StallM},    {31'd0, vecs[i].e_stall});
      chk({n, " rw"},    {31'd0, RegWriteM}, {31'd0, vecs[i].e_rw});
      chk({n, " fault"}, {31'd0, MemFaultM}, {31'd0, vecs[i].e_fault});
      chk({n, " rdata"}, ReadDataM, vecs[i].e_rdata);
      chk({n, " rd"},    {27'd0, RdM}, {27'd0, vecs[i].rd});
      chk({n, " pc4"},   PCPlus4M, vecs[i].alu + 32'd4);
      if (vecs[i].e_req) begin
        chk({n, " addr"}, DMemAddr, {vecs[i].alu[31:2], 2'b00});
        chk({n, " be"},   {28'd0, DMemBe}, {28'd0, vecs[i].e_be});
        chk({n, " wdata"}, DMemWData, vecs[i].e_wd);
      end
    end

    // sh at 0x102 with three wait cycles
    @(negedge clk);
    drive_e(0, 1, 2'b00, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
    DMemReady = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sh stall%0d", k), {31'd0, StallM}, 32'd1);
      chk($sformatf("sh req%0d", k),   {31'd0, DMemReq}, 32'd1);
      chk($sformatf("sh addr%0d", k),  DMemAddr, 32'h100);
      chk($sformatf("sh be%0d", k),    {28'd0, DMemBe}, 32'hC);
      chk($sformatf("sh wd%0d", k),    DMemWData, 32'hABCDABCD);
      chk($sformatf("sh we%0d", k),    {31'd0, DMemWe}, 32'd1);
      @(negedge clk);
      if (k == 0) drive_e(1, 0, 2'b00, 3'b000, 32'h77, 32'h0, 5'd7);
      if (k == 2) DMemReady = 1'b1;
      else @(posedge clk);
    end
    #1;
    chk("sh done stall", {31'd0, StallM},  32'd0);
    chk("sh done req",   {31'd0, DMemReq}, 32'd1);
    chk("sh done rd",    {27'd0, RdM},     32'd0);
    @(posedge clk);
    #1;
    chk("sh next rd",    {27'd0, RdM},     32'd7);
    chk("sh next rw",    {31'd0, RegWriteM}, 32'd1);
    chk("sh next req",   {31'd0, DMemReq}, 32'd0);

    // Timeout: lw that never gets ready
    @(negedge clk);
    drive_e(1, 0, 2'b01, 3'b010, 32'h200, 32'h0, 5'd9);
    DMemReady = 1'b0;
    @(posedge clk);
    #1;
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (StallM) begin
        stalls++;
      end else begin
        done = 1'b1;
        chk("to fault", {31'd0, MemFaultM}, 32'd1);
        chk("to req",   {31'd0, DMemReq},   32'd0);
        chk("to rw",    {31'd0, RegWriteM}, 32'd0);
        break;
      end
      if (k == 1) chk("to dbg", {31'd0, DbgState}, 32'd1);
      @(negedge clk);
      if (k == 0) drive_e(1, 0, 2'b00, 3'b000, 32'h88, 32'h0, 5'd12);
      @(posedge clk);
      #1;
    end
    chk("to ended", {31'd0, done}, 32'd1);
    chk("to stalls", stalls, 32'd15);
    @(posedge clk);
    #1;
    chk("to next rd",    {27'd0, RdM},       32'd12);
    chk("to next fault", {31'd0, MemFaultM}, 32'd0);
    chk("to next rw",    {31'd0, RegWriteM}, 32'd1);
    chk("to next dbg",   {31'd0, DbgState},  32'd0);

    // Reset asserted while waiting
    @(negedge clk);
    drive_e(1, 0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd3);
    DMemReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rw-wait stall", {31'd0, StallM},  32'd1);
    chk("rw-wait req",   {31'd0, DMemReq}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst req",   {31'd0, DMemReq},   32'd0);
    chk("arst stall", {31'd0, StallM},    32'd0);
    chk("arst rw",    {31'd0, RegWriteM}, 32'd0);
    chk("arst rd",    {27'd0, RdM},       32'd0);
    chk("arst alu",   ALUResultM,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_e(1, 0, 2'b00, 3'b000, 32'h55, 32'h0, 5'd5);
    @(posedge clk);
    #1;
    chk("post rd",    {27'd0, RdM},       32'd5);
    chk("post rw",    {31'd0, RegWriteM}, 32'd1);
    chk("post stall", {31'd0, StallM},    32'd0);
    chk("post alu",   ALUResultM,         32'h55);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
